// File: rtl/instr_fetch.sv
// instr_fetch -- program sequencer feeding the accumulator datapath.
//
// Fetches from a byte-wide synchronous program memory. Each instruction is a 3-byte
// big-endian opcode, followed by one operand byte when the opcode is LDA. The assembled
// instruction is presented to the accumulator in a one-cycle ISSUE state, which is
// stretched for as long as the consumer applies back-pressure.
//
// Every opcode other than LDA is issued without an operand. INC and DEC therefore need
// no decoding here and are not parameters of this block.
//
// Build option:
//   FETCH_HALT_EN  when defined, issuing HLT is followed by a HALT state. HALT does no
//                  reads and waits for start. When undefined, HLT is an ordinary
//                  no-operand opcode and halted_o is tied low.
//
// Parameters:
//   ADDR_W    program counter / memory address width
//   RESET_PC  PC value loaded on reset
//   LDA       load-accumulator opcode (takes one operand byte)
//   HLT       halt opcode (exists only with FETCH_HALT_EN)
//
// Ports:
//   clk_i          clock, rising edge
//   fetch_rst_i    synchronous active-high reset
//   start_i        begin fetching from current PC (honoured in IDLE/HALT only)
//   op_stall_i     consumer back-pressure, holds ISSUE
//   mem_rdata_i    program memory read data, valid the cycle after mem_rd_o
//   mem_rd_o       program memory read strobe
//   mem_addr_o     program memory address
//   opcode_o       assembled opcode, stable from one ISSUE to the next
//   op_rdy_o       high in every ISSUE cycle
//   acc_en_o       op_rdy_o & ~op_stall_i, one cycle per issued instruction
//   acc_data_in_o  LDA operand byte, 8'h00 for no-operand opcodes
//   busy_o         high outside IDLE/HALT
//   halted_o       high in HALT
module instr_fetch #(
  parameter int unsigned       ADDR_W   = 8,
  parameter logic [ADDR_W-1:0] RESET_PC = '0,
  parameter logic [23:0]       LDA      = 24'h4C4441
`ifdef FETCH_HALT_EN
  , parameter logic [23:0]     HLT      = 24'h484C54
`endif
) (
  input  logic              clk_i,
  input  logic              fetch_rst_i,
  input  logic              start_i,
  input  logic              op_stall_i,
  input  logic [7:0]        mem_rdata_i,
  output logic              mem_rd_o,
  output logic [ADDR_W-1:0] mem_addr_o,
  output logic [23:0]       opcode_o,
  output logic              op_rdy_o,
  output logic              acc_en_o,
  output logic [7:0]        acc_data_in_o,
  output logic              busy_o,
  output logic              halted_o
);

  typedef enum logic [2:0] {
    S_IDLE,
    S_REQ,
    S_CAP,
    S_ISSUE
`ifdef FETCH_HALT_EN
    , S_HALT
`endif
  } state_e;

  state_e              state_q, state_d;
  logic [ADDR_W-1:0]   pc_q, pc_d;
  logic [1:0]          cnt_q, cnt_d;
  logic [23:0]         shadow_q, shadow_d;
  logic                mem_rd_q, mem_rd_d;
  logic [ADDR_W-1:0]   mem_addr_q, mem_addr_d;
  logic [23:0]         opcode_q, opcode_d;
  logic                op_rdy_q, op_rdy_d;
  logic [7:0]          acc_data_q, acc_data_d;
  logic                busy_q, busy_d;
`ifdef FETCH_HALT_EN
  logic                halted_q, halted_d;
`endif

  // Shadow register with the freshly returned byte appended. After the third opcode
  // byte this holds the complete big-endian opcode.
  logic [23:0] shifted;
  assign shifted = {shadow_q[15:0], mem_rdata_i};

  // Next-state logic. "launch" is the common entry into REQ: issue a read of the
  // current PC. The PC itself only advances at the end of the REQ cycle.
  always_comb begin
    logic launch;
    logic enter_issue;
    launch      = 1'b0;
    enter_issue = 1'b0;
    state_d     = state_q;
    pc_d        = pc_q;
    cnt_d       = cnt_q;
    shadow_d    = shadow_q;
    mem_rd_d    = 1'b0;
    mem_addr_d  = mem_addr_q;
    opcode_d    = opcode_q;
    op_rdy_d    = op_rdy_q;
    acc_data_d  = acc_data_q;
    busy_d      = busy_q;
`ifdef FETCH_HALT_EN
    halted_d    = halted_q;
`endif

    case (state_q)
      S_IDLE: begin
        if (start_i) begin
          launch = 1'b1;
        end
      end

      S_REQ: begin
        pc_d    = pc_q + ADDR_W'(1);
        state_d = S_CAP;
      end

      S_CAP: begin
        if (cnt_q == 2'd3) begin
          // Operand byte: the shadow already holds the LDA opcode.
          opcode_d    = shadow_q;
          acc_data_d  = mem_rdata_i;
          enter_issue = 1'b1;
        end else begin
          shadow_d = shifted;
          if (cnt_q == 2'd2) begin
            if (shifted == LDA) begin
              cnt_d  = 2'd3;
              launch = 1'b1;
            end else begin
              opcode_d    = shifted;
              acc_data_d  = 8'h00;
              enter_issue = 1'b1;
            end
          end else begin
            cnt_d  = cnt_q + 2'd1;
            launch = 1'b1;
          end
        end
      end

      S_ISSUE: begin
        if (!op_stall_i) begin
          op_rdy_d = 1'b0;
`ifdef FETCH_HALT_EN
          if (opcode_q == HLT) begin
            state_d  = S_HALT;
            busy_d   = 1'b0;
            halted_d = 1'b1;
          end else begin
            launch = 1'b1;
          end
`else
          launch = 1'b1;
`endif
        end
      end

`ifdef FETCH_HALT_EN
      S_HALT: begin
        if (start_i) begin
          launch   = 1'b1;
          halted_d = 1'b0;
        end
      end
`endif

      default: begin
        state_d = S_IDLE;
      end
    endcase

    if (enter_issue) begin
      state_d  = S_ISSUE;
      op_rdy_d = 1'b1;
      cnt_d    = 2'd0;
    end

    if (launch) begin
      state_d    = S_REQ;
      mem_rd_d   = 1'b1;
      mem_addr_d = pc_q;
      busy_d     = 1'b1;
    end
  end

  // Single state/output register bank; reset takes priority over any fetch or stall.
  always_ff @(posedge clk_i) begin
    if (fetch_rst_i) begin
      state_q    <= S_IDLE;
      pc_q       <= RESET_PC;
      cnt_q      <= 2'd0;
      shadow_q   <= 24'h0;
      mem_rd_q   <= 1'b0;
      mem_addr_q <= RESET_PC;
      opcode_q   <= 24'h0;
      op_rdy_q   <= 1'b0;
      acc_data_q <= 8'h00;
      busy_q     <= 1'b0;
`ifdef FETCH_HALT_EN
      halted_q   <= 1'b0;
`endif
    end else begin
      state_q    <= state_d;
      pc_q       <= pc_d;
      cnt_q      <= cnt_d;
      shadow_q   <= shadow_d;
      mem_rd_q   <= mem_rd_d;
      mem_addr_q <= mem_addr_d;
      opcode_q   <= opcode_d;
      op_rdy_q   <= op_rdy_d;
      acc_data_q <= acc_data_d;
      busy_q     <= busy_d;
`ifdef FETCH_HALT_EN
      halted_q   <= halted_d;
`endif
    end
  end

  assign mem_rd_o      = mem_rd_q;
  assign mem_addr_o    = mem_addr_q;
  assign opcode_o      = opcode_q;
  assign op_rdy_o      = op_rdy_q;
  // Combinational so the consumer sees the enable in the same cycle it releases the stall.
  assign acc_en_o      = op_rdy_q & ~op_stall_i;
  assign acc_data_in_o = acc_data_q;
  assign busy_o        = busy_q;
`ifdef FETCH_HALT_EN
  assign halted_o      = halted_q;
`else
  assign halted_o      = 1'b0;
`endif

endmodule
